// File: rtl/smart_gate_controller.sv
// Paid-access barrier gate controller: timed light/motor sequence per paid request,
// plus a saturating count of gate openings.
module smart_gate_controller #(
  parameter int PRE_CYCLES   = 2,
  parameter int GREEN_CYCLES = 3,
  parameter int CNT_W        = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             car_i,
  input  logic             pay_ok_i,
  input  logic             clear_i,
  input  logic             cnt_reset_i,
  output logic             gate_open_o,
  output logic             gate_close_o,
  output logic             red_o,
  output logic             yellow_o,
  output logic             green_o,
  output logic [CNT_W-1:0] car_count_o
);

  localparam int MAX_CYC = (PRE_CYCLES > GREEN_CYCLES) ? PRE_CYCLES : GREEN_CYCLES;
  localparam int TMR_W   = ($clog2(MAX_CYC) < 2) ? 2 : $clog2(MAX_CYC);

  // Timer counts down to zero; a state with N cycles is loaded with N-1 on entry.
  localparam logic [TMR_W-1:0] PRE_LOAD   = TMR_W'(PRE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GREEN_LOAD = TMR_W'(GREEN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_YELLOW_PRE,
    S_WAIT_CLEAR,
    S_OPEN,
    S_GREEN,
    S_YELLOW,
    S_CLOSE
  } state_t;

  state_t             state_reg, state_next;
  logic [TMR_W-1:0]   timer_reg, timer_next;
  logic [CNT_W-1:0]   count_reg;
  logic               count_inc;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg <= S_IDLE;
      timer_reg <= '0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_inc  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (car_i && pay_ok_i) state_next = S_YELLOW_PRE;
      end
      S_YELLOW_PRE: begin
        if (timer_reg == '0) state_next = S_WAIT_CLEAR;
      end
      S_WAIT_CLEAR: begin
        if (clear_i) begin
          state_next = S_OPEN;
          count_inc  = 1'b1;
        end
      end
      S_OPEN:   state_next = S_GREEN;
      S_GREEN: begin
        if (timer_reg == '0) state_next = S_YELLOW;
      end
      S_YELLOW: state_next = S_CLOSE;
      S_CLOSE:  state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Reload on every state entry, otherwise count down and rest at zero.
  always_comb begin
    timer_next = timer_reg;
    if (state_next != state_reg) begin
      case (state_next)
        S_YELLOW_PRE: timer_next = PRE_LOAD;
        S_GREEN:      timer_next = GREEN_LOAD;
        default:      timer_next = '0;
      endcase
    end else if (timer_reg != '0) begin
      timer_next = timer_reg - 1'b1;
    end
  end

  // Counter clear wins over a same-edge increment; all-ones is sticky.
  always_ff @(posedge clk_i) begin
    if (reset_i || cnt_reset_i) begin
      count_reg <= '0;
    end else if (count_inc && (count_reg != {CNT_W{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  always_comb begin
    red_o        = 1'b0;
    yellow_o     = 1'b0;
    green_o      = 1'b0;
    gate_open_o  = 1'b0;
    gate_close_o = 1'b0;
    case (state_reg)
      S_IDLE:       red_o = 1'b1;
      S_YELLOW_PRE: yellow_o = 1'b1;
      S_WAIT_CLEAR: yellow_o = 1'b1;
      S_OPEN: begin
        green_o     = 1'b1;
        gate_open_o = clear_i;
      end
      S_GREEN:      green_o = 1'b1;
      S_YELLOW:     yellow_o = 1'b1;
      S_CLOSE: begin
        red_o        = 1'b1;
        gate_close_o = 1'b1;
      end
      default:      red_o = 1'b1;
    endcase
  end

  assign car_count_o = count_reg;

endmodule

// File: tb/tb_smart_gate_controller.sv
// Directed bench for smart_gate_controller: light/motor sequence, lane blocking,
// counter clear and saturation, with per-cycle safety invariants.
module tb_smart_gate_controller;

  logic       clk_i = 1'b0;
  logic       reset_i, car_i, pay_ok_i, clear_i, cnt_reset_i;
  logic       gate_open_o, gate_close_o, red_o, yellow_o, green_o;
  logic [7:0] car_count_o;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  // Packed as {red, yellow, green, open, close}
  localparam logic [4:0] L_RED = 5'b10000;
  localparam logic [4:0] L_YEL = 5'b01000;
  localparam logic [4:0] L_GRN = 5'b00100;
  localparam logic [4:0] M_OPN = 5'b00010;
  localparam logic [4:0] M_CLS = 5'b00001;

  smart_gate_controller #(.PRE_CYCLES(2), .GREEN_CYCLES(3), .CNT_W(8)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .car_i       (car_i),
    .pay_ok_i    (pay_ok_i),
    .clear_i     (clear_i),
    .cnt_reset_i (cnt_reset_i),
    .gate_open_o (gate_open_o),
    .gate_close_o(gate_close_o),
    .red_o       (red_o),
    .yellow_o    (yellow_o),
    .green_o     (green_o),
    .car_count_o (car_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_st(input string tag, input logic [4:0] lights, input logic [7:0] cnt);
    logic [4:0] obs;
    obs = {red_o, yellow_o, green_o, gate_open_o, gate_close_o};
    checks++;
    assert (obs === lights) else begin
      failures++;
      $error("FAIL %s lights observed=%b expected=%b", tag, obs, lights);
    end
    checks++;
    assert (car_count_o === cnt) else begin
      failures++;
      $error("FAIL %s count observed=%0d expected=%0d", tag, car_count_o, cnt);
    end
    $display("step %-14s lights=%b count=%0d", tag, obs, car_count_o);
  endtask

  // Remainder of a passage after the OPEN cycle has been checked.
  task automatic tail(input string tag, input logic [7:0] cnt);
    for (int i = 0; i < 3; i++) begin
      step(); expect_st({tag, "_green"}, L_GRN, cnt);
    end
    step(); expect_st({tag, "_yel"}, L_YEL, cnt);
    step(); expect_st({tag, "_close"}, L_RED | M_CLS, cnt);
    step(); expect_st({tag, "_idle"}, L_RED, cnt);
  endtask

  task automatic passage();
    car_i = 1'b1; pay_ok_i = 1'b1;
    step();
    car_i = 1'b0; pay_ok_i = 1'b0;
    repeat (9) step();
  endtask

  always @(negedge clk_i) begin
    if (mon_en) begin
      checks++;
      assert ((red_o + yellow_o + green_o) == 2'd1) else begin
        failures++;
        $error("FAIL onehot lights observed=%b%b%b expected one high", red_o, yellow_o, green_o);
      end
      checks++;
      assert (!(gate_open_o && gate_close_o)) else begin
        failures++;
        $error("FAIL open_close_both observed=11 expected not both");
      end
      checks++;
      assert (!(gate_open_o && !clear_i)) else begin
        failures++;
        $error("FAIL open_while_blocked observed=1 expected=0");
      end
    end
  end

  initial begin
    reset_i = 1'b1; car_i = 1'b0; pay_ok_i = 1'b0; clear_i = 1'b1; cnt_reset_i = 1'b0;
    repeat (3) step();
    mon_en = 1'b1;
    expect_st("in_reset", L_RED, 8'd0);
    reset_i = 1'b0;
    step(); expect_st("post_reset", L_RED, 8'd0);

    // Partial requests are ignored
    car_i = 1'b1;
    step(); expect_st("car_only", L_RED, 8'd0);
    car_i = 1'b0; pay_ok_i = 1'b1;
    step(); expect_st("pay_only", L_RED, 8'd0);
    pay_ok_i = 1'b0;

    // Passage 1: basic
    car_i = 1'b1; pay_ok_i = 1'b1;
    step(); expect_st("p1_yp1", L_YEL, 8'd0);
    car_i = 1'b0; pay_ok_i = 1'b0;
    step(); expect_st("p1_yp2", L_YEL, 8'd0);
    step(); expect_st("p1_wait", L_YEL, 8'd0);
    step(); expect_st("p1_open", L_GRN | M_OPN, 8'd1);
    tail("p1", 8'd1);

    // Passage 2: lane blocked for 5 WAIT_CLEAR cycles, mid-sequence request ignored
    car_i = 1'b1; pay_ok_i = 1'b1;
    step(); expect_st("p2_yp1", L_YEL, 8'd1);
    car_i = 1'b0; pay_ok_i = 1'b0;
    step(); expect_st("p2_yp2", L_YEL, 8'd1);
    clear_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(); expect_st("p2_blocked", L_YEL, 8'd1);
    end
    clear_i = 1'b1;
    #1 expect_st("p2_released", L_YEL, 8'd1);
    step(); expect_st("p2_open", L_GRN | M_OPN, 8'd2);
    clear_i = 1'b0;
    #1 expect_st("p2_open_gated", L_GRN, 8'd2);
    clear_i = 1'b1;
    car_i = 1'b1; pay_ok_i = 1'b1;
    step(); expect_st("p2_green_req", L_GRN, 8'd2);
    step(); expect_st("p2_green_req", L_GRN, 8'd2);
    car_i = 1'b0; pay_ok_i = 1'b0;
    step(); expect_st("p2_green", L_GRN, 8'd2);
    step(); expect_st("p2_yel", L_YEL, 8'd2);
    step(); expect_st("p2_close", L_RED | M_CLS, 8'd2);
    step(); expect_st("p2_idle", L_RED, 8'd2);

    // Passage 3: counter cleared during GREEN; request held over CLOSE
    car_i = 1'b1; pay_ok_i = 1'b1;
    step(); expect_st("p3_yp1", L_YEL, 8'd2);
    car_i = 1'b0; pay_ok_i = 1'b0;
    step(); expect_st("p3_yp2", L_YEL, 8'd2);
    step(); expect_st("p3_wait", L_YEL, 8'd2);
    step(); expect_st("p3_open", L_GRN | M_OPN, 8'd3);
    step(); expect_st("p3_green1", L_GRN, 8'd3);
    cnt_reset_i = 1'b1;
    step(); expect_st("p3_cnt_clr", L_GRN, 8'd0);
    cnt_reset_i = 1'b0;
    step(); expect_st("p3_green3", L_GRN, 8'd0);
    step(); expect_st("p3_yel", L_YEL, 8'd0);
    step(); expect_st("p3_close", L_RED | M_CLS, 8'd0);
    car_i = 1'b1; pay_ok_i = 1'b1;
    step(); expect_st("p3_idle_held", L_RED, 8'd0);

    // Passage 4: held request taken on first IDLE edge; clear beats increment
    step(); expect_st("p4_yp1", L_YEL, 8'd0);
    car_i = 1'b0; pay_ok_i = 1'b0;
    step(); expect_st("p4_yp2", L_YEL, 8'd0);
    step(); expect_st("p4_wait", L_YEL, 8'd0);
    cnt_reset_i = 1'b1;
    step(); expect_st("p4_open_clr", L_GRN | M_OPN, 8'd0);
    cnt_reset_i = 1'b0;
    tail("p4", 8'd0);

    // Passage 5: reset mid-GREEN aborts without a close pulse
    car_i = 1'b1; pay_ok_i = 1'b1;
    step(); expect_st("p5_yp1", L_YEL, 8'd0);
    car_i = 1'b0; pay_ok_i = 1'b0;
    step(); expect_st("p5_yp2", L_YEL, 8'd0);
    step(); expect_st("p5_wait", L_YEL, 8'd0);
    step(); expect_st("p5_open", L_GRN | M_OPN, 8'd1);
    step(); expect_st("p5_green", L_GRN, 8'd1);
    reset_i = 1'b1;
    step(); expect_st("p5_abort", L_RED, 8'd0);
    reset_i = 1'b0;
    step(); expect_st("p5_idle1", L_RED, 8'd0);
    step(); expect_st("p5_idle2", L_RED, 8'd0);

    // Saturation over 260 passages
    for (int i = 0; i < 254; i++) passage();
    expect_st("sat_254", L_RED, 8'd254);
    passage();
    expect_st("sat_255", L_RED, 8'd255);
    for (int i = 0; i < 5; i++) passage();
    expect_st("sat_260", L_RED, 8'd255);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/smart_gate_controller.md
# smart_gate_controller

Controller for a paid-access barrier gate: one traffic light (red/yellow/green), open/close motor pulses and a saturating passage counter. A paid request (car present with payment confirmed) starts a fixed, timed sequence: warn, wait for the lane to be clear, open, hold green, warn, close. It sits between the lane sensors and payment terminal on one side and the gate motor driver and signal lamps on the other.

## Interface
- PRE_CYCLES, default 2: cycles spent in YELLOW_PRE.
- GREEN_CYCLES, default 3: cycles spent in GREEN after OPEN.
- CNT_W, default 8: width of car_count_o; the counter saturates at 2^CNT_W-1.
- clk_i  in  1  single clock; everything updates on the rising edge.
- reset_i  in  1  synchronous, active-high reset.
- car_i  in  1  vehicle present at the gate.
- pay_ok_i  in  1  payment accepted.
- clear_i  in  1  lane beyond the gate is clear (1 = safe to open).
- cnt_reset_i  in  1  synchronous clear of the passage counter.
- gate_open_o  out  1  one-cycle open command to the motor.
- gate_close_o  out  1  one-cycle close command to the motor.
- red_o, yellow_o, green_o  out  1 each  light outputs; exactly one is high at all times.
- car_count_o  out  CNT_W  number of gate openings, saturating.

## Operation
- FSM states and their outputs:
  - IDLE: red.
  - YELLOW_PRE: yellow.
  - WAIT_CLEAR: yellow.
  - OPEN: green, and gate_open_o = clear_i.
  - GREEN: green.
  - YELLOW: yellow.
  - CLOSE: red, and gate_close_o = 1.
- All outputs are decoded from registered state. The only combinational dependency is gate_open_o, which is gated by clear_i.
- State transitions:
  - IDLE -> YELLOW_PRE when car_i & pay_ok_i is 1 at the edge. Otherwise stay in IDLE.
  - YELLOW_PRE -> WAIT_CLEAR after exactly PRE_CYCLES cycles.
  - WAIT_CLEAR -> OPEN on the first edge where clear_i = 1. Otherwise stay, for an unbounded time.
  - OPEN -> GREEN after 1 cycle, unconditionally.
  - GREEN -> YELLOW after exactly GREEN_CYCLES cycles.
  - YELLOW -> CLOSE after 1 cycle.
  - CLOSE -> IDLE after 1 cycle.
- car_i and pay_ok_i are ignored in every state except IDLE. car_i alone, or pay_ok_i alone, does nothing.
- An internal cycle counter (at least 2 bits) times YELLOW_PRE and GREEN. It is reloaded on every state entry.
- Passage counter:
  - Increments by 1 on the edge where WAIT_CLEAR -> OPEN is taken, so the new value is visible during OPEN.
  - Holds at all-ones (255 by default); it never wraps.
- cnt_reset_i = 1 clears the counter to 0 on that edge.
  - It has priority over a simultaneous increment.
  - It has no effect on the FSM, lights or motor outputs.
- gate_open_o and gate_close_o are never high together. gate_open_o is never high while clear_i = 0.

## Timing
- reset_i = 1 at an edge forces the following, from any state (reset mid-sequence aborts it without emitting a close pulse):
  - state to IDLE;
  - timer to 0;
  - car_count_o to 0.
- Output values in reset and immediately after it: red_o=1, yellow_o=0, green_o=0, gate_open_o=0, gate_close_o=0, car_count_o=0.
- Request latency: a request sampled at edge E0 gives yellow from E0.
  - Yellow lasts PRE_CYCLES + 1 cycles when clear_i = 1 throughout.
  - OPEN, with green and the gate_open_o pulse, runs from E0+3 to E0+4.
  - Green lasts 1 + GREEN_CYCLES = 4 cycles in total.
  - Then 1 cycle of yellow.
  - Then CLOSE: red plus the gate_close_o pulse.
  - Then IDLE.
- Full sequence with clear_i = 1: 9 cycles from the request edge back to IDLE.
- IDLE lasts at least 1 cycle after CLOSE. A request held high during CLOSE is taken on the first IDLE edge.
- If clear_i drops in WAIT_CLEAR, the gate stays yellow with gate_open_o = 0. When clear_i rises and is sampled at an edge, OPEN starts on that edge.
- cnt_reset_i sampled at edge E gives car_count_o = 0 from E.

## Test plan
- Reset: hold reset_i for 2 or more cycles, then release. Required: red=1, yellow=0, green=0, open=0, close=0, count=0.
- Basic passage, clear_i=1, car_i=pay_ok_i=1 for one cycle. Required, in order:
  - yellow ×3;
  - green + open ×1;
  - green ×3;
  - yellow ×1;
  - red + close ×1;
  - red idle.
  - count=1.
- Lane blocked: drive clear_i=0 from the WAIT_CLEAR cycle for 5 cycles. Required: yellow held and open=0 throughout. Release clear_i, then one more yellow cycle, then OPEN. The rest of the sequence is unchanged; count=2.
- Counter clear during GREEN: pulse cnt_reset_i for 1 cycle. Required: count=0 on the next cycle, green still on, no motor pulse, sequence completes normally.
- Saturation: run 260 passages. Required: car_count_o = 255, not wrapped.
- Every cycle: exactly one light high; open and close never both high; open never high while clear_i = 0. Also check that car_i without pay_ok_i, and a request issued mid-sequence, are both ignored.
